axis_merge: RTL and testbench

AXIS_MERGE -- requirements
Module: axis_merge

---
 rtl/axis_merge.sv | 134 +++++++++++++
 tb/tb_axis_merge.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_merge.sv
// Packet-atomic round-robin merge of NS AXI-Stream inputs onto one registered output.
// TID carries the index of the source port of each output beat.
module axis_merge #(
    parameter int unsigned  C_AXIS_DATA_WIDTH = 16,
    parameter int unsigned  NS                = 4,
    localparam int unsigned IW                = (NS > 1) ? $clog2(NS) : 1
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic [NS-1:0]                 S_AXIS_TVALID,
    output logic [NS-1:0]                 S_AXIS_TREADY,
    input  logic [NS*C_AXIS_DATA_WIDTH-1:0] S_AXIS_TDATA,
    input  logic [NS-1:0]                 S_AXIS_TLAST,
    output logic                          M_AXIS_TVALID,
    input  logic                          M_AXIS_TREADY,
    output logic [C_AXIS_DATA_WIDTH-1:0]  M_AXIS_TDATA,
    output logic                          M_AXIS_TLAST,
    output logic [IW-1:0]                 M_AXIS_TID
);

    localparam int unsigned DW = C_AXIS_DATA_WIDTH;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [IW-1:0] grant;
    logic [IW-1:0] grant_nx;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] last_grant_nx;
    logic [IW-1:0] rr_pick;
    int unsigned   rr_dist;
    int unsigned   rr_best;
    logic          sel_valid;
    logic          sel_last;
    logic [DW-1:0] sel_data;
    logic          out_free;
    logic          accept;

    // Round-robin pick: requester closest after last_grant (modulo NS) wins.
    always_comb begin
        rr_pick = '0;
        rr_best = NS;
        rr_dist = 0;
        for (int unsigned j = 0; j < NS; j++) begin
            rr_dist = (j + NS - 32'(last_grant) - 1) % NS;
            if (S_AXIS_TVALID[j] && (rr_dist < rr_best)) begin
                rr_best = rr_dist;
                rr_pick = IW'(j);
            end
        end
    end

    // Granted-port mux.
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        for (int unsigned j = 0; j < NS; j++) begin
            if (grant == IW'(j)) begin
                sel_valid = S_AXIS_TVALID[j];
                sel_last  = S_AXIS_TLAST[j];
                sel_data  = S_AXIS_TDATA[j*DW +: DW];
            end
        end
    end

    assign out_free = !M_AXIS_TVALID || M_AXIS_TREADY;
    assign accept   = (state == BUSY) && sel_valid && out_free;

    // Ready is combinational so the output register can refill in the cycle it drains.
    always_comb begin
        S_AXIS_TREADY = '0;
        if (state == BUSY) begin
            for (int unsigned j = 0; j < NS; j++) begin
                S_AXIS_TREADY[j] = out_free && (grant == IW'(j));
            end
        end
    end

    always_comb begin
        state_nx      = state;
        grant_nx      = grant;
        last_grant_nx = last_grant;
        case (state)
            IDLE: begin
                if (|S_AXIS_TVALID) begin
                    grant_nx = rr_pick;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    state_nx      = IDLE;
                    last_grant_nx = grant;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= IW'(NS - 1);
        end else begin
            state      <= state_nx;
            grant      <= grant_nx;
            last_grant <= last_grant_nx;
        end
    end

    // Output register: load on accept, drain on downstream handshake, else hold.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            M_AXIS_TVALID <= 1'b0;
            M_AXIS_TDATA  <= '0;
            M_AXIS_TLAST  <= 1'b0;
            M_AXIS_TID    <= '0;
        end else if (accept) begin
            M_AXIS_TVALID <= 1'b1;
            M_AXIS_TDATA  <= sel_data;
            M_AXIS_TLAST  <= sel_last;
            M_AXIS_TID    <= grant;
        end else if (M_AXIS_TVALID && M_AXIS_TREADY) begin
            M_AXIS_TVALID <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_merge.sv
// Bench for axis_merge: per-port source queues feed the DUT, and every output beat is
// checked against the next beat of the port its TID names, plus timing/ordering checks.
module tb_axis_merge;

    localparam int DW = 16;
    localparam int NS = 4;
    localparam int IW = 2;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NS-1:0]    s_valid;
    logic [NS-1:0]    s_ready;
    logic [NS*DW-1:0] s_data;
    logic [NS-1:0]    s_last;
    logic             m_valid;
    logic             m_ready;
    logic [DW-1:0]    m_data;
    logic             m_last;
    logic [IW-1:0]    m_tid;

    always #5 clk = ~clk;

    axis_merge #(.C_AXIS_DATA_WIDTH(DW), .NS(NS)) dut (
        .S_AXI_ACLK    (clk),
        .S_AXI_ARESETN (rst_n),
        .S_AXIS_TVALID (s_valid),
        .S_AXIS_TREADY (s_ready),
        .S_AXIS_TDATA  (s_data),
        .S_AXIS_TLAST  (s_last),
        .M_AXIS_TVALID (m_valid),
        .M_AXIS_TREADY (m_ready),
        .M_AXIS_TDATA  (m_data),
        .M_AXIS_TLAST  (m_last),
        .M_AXIS_TID    (m_tid)
    );

    // Source memories: {last, data} per beat, write pointer, accepted pointer, output pointer.
    logic [DW:0]   mem [NS][256];
    int            src_wr [NS];
    int            src_rd [NS];
    int            exp_rd [NS];
    int            mb_cyc [$];
    int            mb_tid [$];
    int            mr_q [$];
    int            n_chk;
    int            n_bad;
    int            cyc;
    int            vprob;
    int            mprob;
    bit            in_pkt;
    bit            stall;
    int            cur_tid;
    logic [DW-1:0] st_data;
    logic [IW-1:0] st_tid;
    logic          st_last;
    logic [NS-1:0] hs;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < NS; p++) begin
            src_wr[p] = 0;
            src_rd[p] = 0;
            exp_rd[p] = 0;
        end
        mb_cyc.delete();
        mb_tid.delete();
        mr_q.delete();
        in_pkt  = 1'b0;
        stall   = 1'b0;
        hs      = '0;
        s_valid = '0;
        m_ready = 1'b0;
    endtask

    task automatic add_pkt(input int p, input int len, input int base, input bit rnd);
        logic [DW-1:0] d;
        for (int i = 0; i < len; i++) begin
            d = rnd ? DW'($urandom) : DW'(base + i);
            mem[p][src_wr[p]] = {(i == len - 1), d};
            src_wr[p]++;
        end
    endtask

    // Sources keep valid/data until accepted; otherwise offer the next pending beat at random.
    task automatic drive();
        for (int p = 0; p < NS; p++) begin
            if (!(s_valid[p] && !hs[p]))
                s_valid[p] = (src_rd[p] < src_wr[p]) && ($urandom_range(99) < vprob);
            s_data[p*DW +: DW] = mem[p][src_rd[p]][DW-1:0];
            s_last[p]          = mem[p][src_rd[p]][DW];
        end
        hs = '0;
        if (mr_q.size() > 0) m_ready = (mr_q.pop_front() != 0);
        else                 m_ready = ($urandom_range(99) < mprob);
    endtask

    task automatic sb_beat();
        int t;
        t = int'(m_tid);
        if (in_pkt) chk("pkt_contig", 32'(m_tid), 32'(cur_tid));
        chk("no_dup", 32'(exp_rd[t] < src_rd[t]), 1);
        if (exp_rd[t] < 255) begin
            chk("data", 32'(m_data), 32'(mem[t][exp_rd[t]][DW-1:0]));
            chk("last", 32'(m_last), 32'(mem[t][exp_rd[t]][DW]));
            exp_rd[t]++;
        end
        in_pkt  = !m_last;
        cur_tid = t;
        mb_cyc.push_back(cyc);
        mb_tid.push_back(t);
    endtask

    task automatic cycle();
        @(negedge clk);
        if (stall) begin
            chk("hold_valid", 32'(m_valid), 1);
            chk("hold_data", 32'(m_data), 32'(st_data));
            chk("hold_tid", 32'(m_tid), 32'(st_tid));
            chk("hold_last", 32'(m_last), 32'(st_last));
        end
        chk("ready_onehot", 32'($countones(s_ready) <= 1), 1);
        if (m_valid && m_ready) sb_beat();
        stall   = m_valid && !m_ready;
        st_data = m_data;
        st_tid  = m_tid;
        st_last = m_last;
        hs      = s_valid & s_ready;
        for (int p = 0; p < NS; p++)
            if (hs[p]) src_rd[p]++;
        @(posedge clk);
        #1;
        cyc++;
        drive();
    endtask

    task automatic run_until(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (mb_tid.size() < n && k < budget) begin
            cycle();
            k++;
        end
        chk(tag, 32'(mb_tid.size()), 32'(n));
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_mvalid"}, 32'(m_valid), 0);
        chk({tag, "_mdata"}, 32'(m_data), 0);
        chk({tag, "_mlast"}, 32'(m_last), 0);
        chk({tag, "_mtid"}, 32'(m_tid), 0);
        chk({tag, "_sready"}, 32'(s_ready), 0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        model_clear();
        vprob = 100;
        mprob = 100;
        repeat (2) @(posedge clk);
        #1;
        chk_zero("rst");
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        int tot;
        n_chk  = 0;
        n_bad  = 0;
        cyc    = 0;
        rst_n  = 1'b0;
        s_data = '0;
        s_last = '0;
        model_clear();
        #1;
        chk_zero("por");

        // Single port, three beats, latency and back-to-back throughput
        do_reset();
        add_pkt(2, 3, 'hA1, 1'b0);
        drive();
        n = 0;
        do begin
            cycle();
            n++;
        end while (!m_valid && n < 10);
        chk("t024_latency", 32'(n), 2);
        run_until(3, 20, "t024_cnt");
        for (int i = 0; i < 3; i++) chk("t024_tid", 32'(mb_tid[i]), 2);
        for (int i = 1; i < 3; i++) chk("t024_gap", 32'(mb_cyc[i] - mb_cyc[i-1]), 1);

        // Round robin over single-beat packets, one idle cycle between packets
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < NS; p++) add_pkt(p, 1, p * 16 + k, 1'b0);
        drive();
        run_until(8, 100, "t025_cnt");
        for (int i = 0; i < 8; i++) chk("t025_tid", 32'(mb_tid[i]), 32'(i % NS));
        for (int i = 1; i < 8; i++) chk("t025_gap", 32'(mb_cyc[i] - mb_cyc[i-1]), 2);

        // Atomicity: port 1 requests in the middle of a port-0 packet
        do_reset();
        add_pkt(0, 4, 'h10, 1'b0);
        drive();
        repeat (2) cycle();
        add_pkt(1, 1, 'h20, 1'b0);
        run_until(5, 50, "t026_cnt");
        for (int i = 0; i < 5; i++) chk("t026_tid", 32'(mb_tid[i]), (i < 4) ? 0 : 1);

        // Backpressure pattern on the master side
        do_reset();
        for (int k = 0; k < 6; k++) begin
            mr_q.push_back(1); mr_q.push_back(0); mr_q.push_back(0); mr_q.push_back(1);
        end
        add_pkt(0, 5, 'h30, 1'b0);
        drive();
        run_until(5, 80, "t027_cnt");
        chk("t027_all_out", 32'(exp_rd[0]), 5);

        // Asynchronous reset mid-packet, then port 0 must win against port 3
        do_reset();
        add_pkt(1, 5, 'h40, 1'b0);
        drive();
        run_until(2, 30, "t028_pre");
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("t028_async");
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        add_pkt(0, 1, 'h50, 1'b0);
        add_pkt(3, 1, 'h53, 1'b0);
        drive();
        run_until(2, 30, "t028_cnt");
        chk("t028_first", 32'(mb_tid[0]), 0);
        chk("t028_second", 32'(mb_tid[1]), 3);

        // Random packets, gaps and backpressure
        do_reset();
        vprob = 70;
        mprob = 60;
        tot   = 0;
        for (int p = 0; p < NS; p++)
            for (int k = 0; k < 10; k++) begin
                n = int'($urandom_range(1, 4));
                add_pkt(p, n, 0, 1'b1);
                tot += n;
            end
        drive();
        run_until(tot, 4000, "rnd_cnt");
        for (int p = 0; p < NS; p++) begin
            chk("rnd_out_vs_acc", 32'(exp_rd[p]), 32'(src_rd[p]));
            chk("rnd_acc_vs_src", 32'(src_rd[p]), 32'(src_wr[p]));
        end
        chk("rnd_pkt_closed", 32'(in_pkt), 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
